// File: rtl/axicb_slv_ooo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// axicb_ooo_pkg
// Shared definitions for the slave-side completion reorder controller:
//   LEN_W      : width of the stored ALEN field
//   IDLE/BUSY  : FSM state encodings of the completion arbiter
//   slot_of()  : ID-to-slot hash (XOR with the master ID mask); callers cast
//                the result down to their slot index width.
// The per-slot entry struct lives in the top level because its field widths
// follow the module parameters (AXI_ID_W, SLV_NB).
// -----------------------------------------------------------------------------
package axicb_ooo_pkg;

   localparam int unsigned LEN_W = 8;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   function automatic logic [31:0] slot_of(input logic [31:0] id, input logic [31:0] mask);
      return id ^ mask;
   endfunction

endpackage

// File: rtl/axicb_slv_ooo_ctrl_if.sv
// -----------------------------------------------------------------------------
// axicb_slv_ooo_ctrl_if
// Bundles the address-channel tracking, completion-arbiter and status signals
// of axicb_slv_ooo_ctrl.
//   slave  modport : controller view (address/completion inputs, grant outputs)
//   master modport : surrounding crossbar view
// Signals:
//   a_valid/a_ready/a_full/a_len/a_id/a_ix/a_mr : address channel tracking
//   c_en/c_grant/c_mr/c_len/c_id                : completion grant
//   c_valid/c_ready/c_last/c_ch                 : slave completion channels
//   c_lenerr                                    : beat count mismatch pulse
//   ostd_cnt                                    : outstanding entry count
// -----------------------------------------------------------------------------
interface axicb_slv_ooo_ctrl_if #(
   parameter int AXI_ID_W = 8,
   parameter int SLV_NB   = 4,
   parameter int NB_SLOT  = 4,
   parameter int ID_DEPTH = 4,
   parameter int CCH_W    = 8
);
   localparam int OSTD_W = $clog2(NB_SLOT*ID_DEPTH+1);

   logic                    a_valid;
   logic                    a_ready;
   logic                    a_full;
   logic [7:0]              a_len;
   logic [AXI_ID_W-1:0]     a_id;
   logic [SLV_NB-1:0]       a_ix;
   logic                    a_mr;
   logic                    c_en;
   logic [SLV_NB-1:0]       c_grant;
   logic                    c_mr;
   logic [7:0]              c_len;
   logic [AXI_ID_W-1:0]     c_id;
   logic [SLV_NB-1:0]       c_valid;
   logic                    c_ready;
   logic [SLV_NB-1:0]       c_last;
   logic [CCH_W*SLV_NB-1:0] c_ch;
   logic                    c_lenerr;
   logic [OSTD_W-1:0]       ostd_cnt;

   modport slave (
      input  a_valid, a_ready, a_len, a_id, a_ix, a_mr,
      input  c_en, c_valid, c_ready, c_last, c_ch,
      output a_full, c_grant, c_mr, c_len, c_id, c_lenerr, ostd_cnt
   );

   modport master (
      output a_valid, a_ready, a_len, a_id, a_ix, a_mr,
      output c_en, c_valid, c_ready, c_last, c_ch,
      input  a_full, c_grant, c_mr, c_len, c_id, c_lenerr, ostd_cnt
   );

endinterface

// File: rtl/axicb_slv_ooo_ctrl_slot.sv
// -----------------------------------------------------------------------------
// axicb_ooo_slot
// One per-ID-slot queue: DEPTH-entry FIFO with an extra pointer MSB to tell
// full from empty. Push and pop in the same cycle are both performed; the
// caller only pushes into a full queue when it pops in the same cycle.
// Ports:
//   aclk, areset (async, active high), srst (sync clear)
//   push/din     : write an entry
//   pop          : retire the head entry
//   dout         : head entry (valid when !empty)
//   full/empty   : occupancy flags
// -----------------------------------------------------------------------------
module axicb_ooo_slot #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         srst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wptr <= '0;
         rptr <= '0;
      end else if (srst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only observed once the pointers say so.
   always_ff @(posedge aclk) begin
      if (push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/axicb_slv_ooo_ctrl.sv
// -----------------------------------------------------------------------------
// axicb_slv_ooo_ctrl
// Per-master completion reorder controller on the crossbar slave side.
// Address attributes are queued per ID slot; a round-robin arbiter grants one
// slot at a time to the slave recorded at its queue head, and holds the grant
// for the whole burst. On the read path returned beats are counted against
// ALEN and a mismatch is flagged.
// Ports:
//   aclk   : clock
//   areset : asynchronous active-high reset
//   srst   : synchronous active-high clear (same effect as areset)
//   bus    : axicb_slv_ooo_ctrl_if.slave (address, completion, status)
// -----------------------------------------------------------------------------
module axicb_slv_ooo_ctrl
   import axicb_ooo_pkg::*;
#(
   parameter int          RD_PATH     = 0,
   parameter int          AXI_ID_W    = 8,
   parameter int          SLV_NB      = 4,
   parameter int          NB_SLOT     = 4,
   parameter int          ID_DEPTH    = 4,
   parameter int unsigned MST_ID_MASK = 'h00,
   parameter int          CCH_W       = 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  srst,
   axicb_slv_ooo_ctrl_if.slave   bus
);
   localparam int unsigned SLOT_W = $clog2(NB_SLOT);
   localparam int unsigned OSTD_W = $clog2(NB_SLOT*ID_DEPTH+1);

   typedef logic [SLOT_W-1:0] slot_t;

   typedef struct packed {
      logic [LEN_W-1:0]    len;
      logic [SLV_NB-1:0]   ix;
      logic                mr;
      logic [AXI_ID_W-1:0] id;
   } ent_t;

   localparam int unsigned ENT_W = $bits(ent_t);

   ent_t               din;
   ent_t               head [NB_SLOT];
   ent_t               hd;
   logic [NB_SLOT-1:0] full;
   logic [NB_SLOT-1:0] empty;
   logic [NB_SLOT-1:0] push;
   logic [NB_SLOT-1:0] pop;
   logic [NB_SLOT-1:0] req;
   slot_t              ch_slot [SLV_NB];
   slot_t              a_slot;
   slot_t              g;
   slot_t              rr_ptr;
   slot_t              rr_idx;
   slot_t              sel;
   logic               found;
   logic [0:0]         state;
   logic [8:0]         beat_cnt;
   logic               lenerr;
   logic [OSTD_W-1:0]  ostd;
   logic               push_ok;
   logic               beat;
   logic               last_hit;
   logic               done;

   // ---------------------------------------------------------------- queues
   assign a_slot  = slot_t'(slot_of(32'(bus.a_id), 32'(MST_ID_MASK)));
   assign push_ok = bus.a_valid && bus.a_ready;

   always_comb begin
      din     = '0;
      din.len = (RD_PATH != 0) ? bus.a_len : '0;
      din.ix  = bus.a_ix;
      din.mr  = bus.a_mr;
      din.id  = bus.a_id;
   end

   for (genvar s = 0; s < NB_SLOT; s++) begin : g_slot
      // A full slot still takes a push in the cycle its head is retired.
      assign push[s] = push_ok && (a_slot == slot_t'(s)) && (!full[s] || pop[s]);
      assign pop[s]  = done && (g == slot_t'(s));

      axicb_ooo_slot #(
         .W     (ENT_W),
         .DEPTH (ID_DEPTH)
      ) u_slot (
         .aclk   (aclk),
         .areset (areset),
         .srst   (srst),
         .push   (push[s]),
         .pop    (pop[s]),
         .din    (din),
         .dout   (head[s]),
         .full   (full[s]),
         .empty  (empty[s])
      );
   end

   assign bus.a_full = full[a_slot];

   // ------------------------------------------------------------- requests
   always_comb begin
      for (int unsigned j = 0; j < SLV_NB; j++) begin
         ch_slot[j] = slot_t'(slot_of(32'(bus.c_ch[j*CCH_W +: AXI_ID_W]), 32'(MST_ID_MASK)));
      end
   end

   // A slot requests only when the slave named by its head entry presents a
   // completion whose ID hashes back to this slot.
   always_comb begin
      req = '0;
      for (int unsigned s = 0; s < NB_SLOT; s++) begin
         for (int unsigned j = 0; j < SLV_NB; j++) begin
            if (!empty[s] && head[s].ix[j] && bus.c_valid[j] && (ch_slot[j] == slot_t'(s)))
               req[s] = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------- round robin
   always_comb begin
      sel    = rr_ptr;
      found  = 1'b0;
      rr_idx = rr_ptr;
      for (int unsigned k = 0; k < NB_SLOT; k++) begin
         rr_idx = rr_ptr + slot_t'(k);
         if (!found && req[rr_idx]) begin
            sel   = rr_idx;
            found = 1'b1;
         end
      end
   end

   // ----------------------------------------------------------- burst FSM
   assign hd       = head[g];
   assign beat     = (state == BUSY) && ((bus.c_valid & hd.ix) != '0) && bus.c_ready;
   assign last_hit = ((bus.c_last & hd.ix) != '0);
   assign done     = beat && last_hit;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state    <= IDLE;
         g        <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         lenerr   <= 1'b0;
      end else if (srst) begin
         state    <= IDLE;
         g        <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         lenerr   <= 1'b0;
      end else begin
         lenerr <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.c_en && found) begin
                  g     <= sel;
                  state <= BUSY;
               end
            end
            default: begin
               if (beat) begin
                  if (last_hit) begin
                     state    <= IDLE;
                     rr_ptr   <= slot_t'(g + 1'b1);
                     beat_cnt <= '0;
                     lenerr   <= (RD_PATH != 0) &&
                                 ((beat_cnt + 9'd1) != ({1'b0, hd.len} + 9'd1));
                  end else if (RD_PATH != 0) begin
                     beat_cnt <= beat_cnt + 9'd1;
                  end
               end
            end
         endcase
      end
   end

   // --------------------------------------------------------- outstanding
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ostd <= '0;
      end else if (srst) begin
         ostd <= '0;
      end else begin
         case ({|push, |pop})
            2'b10:   ostd <= ostd + 1'b1;
            2'b01:   ostd <= ostd - 1'b1;
            default: ostd <= ostd;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   assign bus.c_grant  = (state == BUSY) ? hd.ix : '0;
   assign bus.c_id     = (state == BUSY) ? hd.id : '0;
   assign bus.c_mr     = (state == BUSY) ? hd.mr : 1'b0;
   assign bus.c_len    = ((state == BUSY) && (RD_PATH != 0)) ? hd.len : '0;
   assign bus.c_lenerr = lenerr;
   assign bus.ostd_cnt = ostd;

endmodule
